// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the EX-stage iterative multiply/divide unit:
//   - muldiv_op_t    : operation encoding as delivered by the ID/EX register
//   - muldiv_state_t : sequencer states (also exported on the debug port)
//   - MULDIV_ITERS   : default operand width / radix-2 iteration count
//   - muldiv_op_is_div / muldiv_op_is_signed : operation decode helpers
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic muldiv_op_is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic muldiv_op_is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single radix-2 iteration shared by multiply and divide.
// The 2*DATA_W accumulator is interpreted differently per operation:
//   multiply : {partial_product_hi, multiplier_remaining}; shift-add, LSB first
//   divide   : {partial_remainder, dividend_then_quotient}; restoring
//              shift-subtract, quotient bits enter at the LSB
// Ports:
//   i_is_div  - 1 selects the divide step, 0 the multiply step
//   i_acc     - current accumulator
//   i_operand - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   o_acc     - accumulator after one iteration
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic                  i_is_div,
    input  logic [2*DATA_W-1:0]   i_acc,
    input  logic [DATA_W-1:0]     i_operand,
    output logic [2*DATA_W-1:0]   o_acc
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_shifted;
    logic [DATA_W-1:0] w_diff;
    logic              w_ge;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set; the carry lands in bit DATA_W and is kept
        // by the right shift below.
        w_sum = {1'b0, i_acc[2*DATA_W-1:DATA_W]}
              + (i_acc[0] ? {1'b0, i_operand} : {(DATA_W+1){1'b0}});

        // Divide: bring the next dividend bit into the partial remainder.
        // The partial remainder is always below the divisor, so the shifted
        // value fits in DATA_W+1 bits and a successful subtraction fits in
        // DATA_W bits (modular subtract is exact in that case).
        w_shifted = {i_acc[2*DATA_W-1:DATA_W], i_acc[DATA_W-1]};
        w_ge      = (w_shifted >= {1'b0, i_operand});
        w_diff    = w_shifted[DATA_W-1:0] - i_operand;

        if (i_is_div) begin
            o_acc = {(w_ge ? w_diff : w_shifted[DATA_W-1:0]),
                     i_acc[DATA_W-2:0], w_ge};
        end else begin
            o_acc = {w_sum, i_acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
// EX-stage iterative multiply/divide unit owning the architectural HI/LO
// registers. One operation in flight at a time; DATA_W radix-2 iterations
// followed by a sign-fix/writeback cycle.
//
// Handshake: Start__i is taken on any rising edge where the unit is in IDLE
// and Flush__i is low; Busy__o is the not-ready indication and rises on that
// same edge. Start__i seen while busy is dropped (no queuing). Completion is a
// one-cycle Done__o pulse, with DivByZero__o alongside it for a zero divisor.
//
// Ports:
//   clock__i, reset__i       - clock, synchronous active-high reset
//   Start__i, Op__i          - operation valid / select (MULT, MULTU, DIV, DIVU)
//   RegRsData__i             - multiplicand or dividend
//   RegRtData__i             - multiplier or divisor
//   Flush__i                 - abort the in-flight operation
//   Busy__o                  - unit occupied (stall request)
//   Done__o, DivByZero__o    - completion pulses
//   Hi__o, Lo__o             - architectural HI/LO
//   DbgState__o              - current sequencer state (muldiv_state_t)
// -----------------------------------------------------------------------------
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MULDIV_ITERS,
    parameter int CNT_W  = 6
) (
    input  logic              clock__i,
    input  logic              reset__i,
    input  logic              Start__i,
    input  logic [1:0]        Op__i,
    input  logic [DATA_W-1:0] RegRsData__i,
    input  logic [DATA_W-1:0] RegRtData__i,
    input  logic              Flush__i,
    output logic              Busy__o,
    output logic              Done__o,
    output logic              DivByZero__o,
    output logic [DATA_W-1:0] Hi__o,
    output logic [DATA_W-1:0] Lo__o,
    output logic [1:0]        DbgState__o
);

    muldiv_state_t       r_state;
    muldiv_op_t          r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_b;
    logic                r_neg_res;   // negate product / quotient at FIX
    logic                r_neg_rem;   // negate remainder at FIX
    logic                r_dbz_pend;
    logic                r_busy;
    logic                r_done;
    logic                r_dbz;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    muldiv_op_t          w_in_op;
    logic                w_in_div;
    logic                w_in_signed;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [DATA_W-1:0]   w_rs_mag;
    logic [DATA_W-1:0]   w_rt_mag;
    logic                w_run_div;
    logic [2*DATA_W-1:0] w_acc_next;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    // Operand capture. Plain two's-complement negate gives the magnitude; the
    // most negative value maps to itself, which is the correct unsigned
    // magnitude 2^(DATA_W-1).
    always_comb begin
        w_in_op     = muldiv_op_t'(Op__i);
        w_in_div    = muldiv_op_is_div(w_in_op);
        w_in_signed = muldiv_op_is_signed(w_in_op);
        w_rs_neg    = w_in_signed & RegRsData__i[DATA_W-1];
        w_rt_neg    = w_in_signed & RegRtData__i[DATA_W-1];
        w_rs_mag    = w_rs_neg ? -RegRsData__i : RegRsData__i;
        w_rt_mag    = w_rt_neg ? -RegRtData__i : RegRtData__i;
    end

    assign w_run_div = muldiv_op_is_div(r_op);

    muldiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_is_div  (w_run_div),
        .i_acc     (r_acc),
        .i_operand (r_b),
        .o_acc     (w_acc_next)
    );

    // Sign correction applied in FIX. Quotient sign is the XOR of operand
    // signs; the remainder follows the dividend.
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quot = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
        w_rem  = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            r_state    <= IDLE;
            r_op       <= OP_MULT;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_b        <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (Flush__i) begin
            // Abandon any work; HI/LO untouched. A start in the same cycle
            // is dropped.
            r_state    <= IDLE;
            r_dbz_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start__i) begin
                        r_op      <= w_in_op;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_neg_res <= w_rs_neg ^ w_rt_neg;
                        if (w_in_div) begin
                            r_acc     <= {{DATA_W{1'b0}}, w_rs_mag};
                            r_b       <= w_rt_mag;
                            r_neg_rem <= w_rs_neg;
                        end else begin
                            r_acc     <= {{DATA_W{1'b0}}, w_rt_mag};
                            r_b       <= w_rs_mag;
                            r_neg_rem <= 1'b0;
                        end
                        // Zero divisor skips the iterations entirely.
                        if (w_in_div && (RegRtData__i == '0)) begin
                            r_dbz_pend <= 1'b1;
                            r_state    <= FIX;
                        end else begin
                            r_dbz_pend <= 1'b0;
                            r_state    <= ITER;
                        end
                    end
                end
                ITER: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                    r_dbz_pend <= 1'b0;
                    if (r_dbz_pend) begin
                        r_dbz <= 1'b1;
                    end else if (w_run_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*DATA_W-1:DATA_W];
                        r_lo <= w_prod[DATA_W-1:0];
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy__o      = r_busy;
    assign Done__o      = r_done;
    assign DivByZero__o = r_dbz;
    assign Hi__o        = r_hi;
    assign Lo__o        = r_lo;
    assign DbgState__o  = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    // Scoreboard entries: {DivByZero, HI, LO} expected at each Done pulse.
    logic [64:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ex_muldiv_unit #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clock__i     (clk),
        .reset__i     (rst),
        .Start__i     (start),
        .Op__i        (op),
        .RegRsData__i (rs),
        .RegRtData__i (rt),
        .Flush__i     (flush),
        .Busy__o      (busy),
        .Done__o      (done),
        .DivByZero__o (dbz),
        .Hi__o        (hi),
        .Lo__o        (lo),
        .DbgState__o  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic, written with the language operators.
    function automatic logic [64:0] model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = '0;
        sq = '0;
        sr = '0;
        case (m_op)
            2'd0: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'd1: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'd2: begin
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard monitor: every Done pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        logic [64:0] e;
        if (!rst && done) begin
            n_checks++;
            assert (exp_q.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL spurious_done: got done with hi=%h lo=%h, required no done", hi, lo);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {dbz, hi, lo}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; Start is sampled by the following posedge (E0).
    // Returns at the negedge of the cycle after E0 (cycle 1).
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        rs    = a;
        rt    = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for Done, counting busy cycles; cyc is the cycle index
    // relative to the start cycle (cycle 0).
    task automatic wait_done(input int c0, output int cyc, output int busy_n);
        cyc    = c0;
        busy_n = 0;
        while (!done && cyc < c0 + 200) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 65'(done), 65'(1));
        check("busy_low_at_done", 65'(busy), 65'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          cyc;
        int          bn;
        logic [1:0]  r_op_v;
        logic [31:0] a_v;
        logic [31:0] b_v;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'd0;
        rs    = '0;
        rt    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_flags", 65'({busy, done, dbz}), 65'(0));
        check("reset_hilo", {1'b0, hi, lo}, 65'(0));
        check("reset_state", 65'(dbg_state), 65'(0));

        // MULTU all-ones squared: latency and busy length
        exp_q.push_back({1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("busy_after_start", 65'(busy), 65'(1));
        wait_done(1, cyc, bn);
        check("multu_done_cycle", 65'(cyc), 65'(34));
        check("multu_busy_cycles", 65'(bn), 65'(33));

        // MULT -3 * 5, started in the Done cycle of the previous op
        exp_q.push_back({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
        start_op(2'd0, 32'hFFFF_FFFD, 32'd5);
        check("start_in_done_cycle", 65'(busy), 65'(1));
        wait_done(1, cyc, bn);
        check("mult_done_cycle", 65'(cyc), 65'(34));

        // DIV -7 / 2, then the overflow corner
        exp_q.push_back({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, cyc, bn);
        exp_q.push_back({1'b0, 32'h0000_0000, 32'h8000_0000});
        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, cyc, bn);

        // Load HI=0x11, LO=0x22 via 0x22 * 0x80000001, then DIVU by zero
        exp_q.push_back({1'b0, 32'h0000_0011, 32'h0000_0022});
        start_op(2'd1, 32'h0000_0022, 32'h8000_0001);
        wait_done(1, cyc, bn);
        exp_q.push_back({1'b1, 32'h0000_0011, 32'h0000_0022});
        start_op(2'd3, 32'd7, 32'd0);
        check("div0_busy", 65'(busy), 65'(1));
        wait_done(1, cyc, bn);
        check("div0_done_cycle", 65'(cyc), 65'(2));
        @(negedge clk);
        check("div0_pulse_one_cycle", 65'({done, dbz}), 65'(0));

        // MULTU 3*4 with a stray Start held over cycles 5..10
        exp_q.push_back({1'b0, 32'h0, 32'd12});
        start_op(2'd1, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        op    = 2'd3;
        rs    = 32'd100;
        rt    = 32'd0;
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        wait_done(11, cyc, bn);
        check("stray_start_done_cycle", 65'(cyc), 65'(34));
        repeat (40) @(negedge clk);
        check("stray_start_idle", 65'(busy), 65'(0));

        // Flush at cycle 10 of a MULTU 5*7
        start_op(2'd1, 32'd5, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 65'(busy), 65'(0));
        check("flush_state", 65'(dbg_state), 65'(0));
        repeat (40) @(negedge clk);
        check("flush_hilo_kept", {1'b0, hi, lo}, {33'b0, 32'd12});

        // Flush together with Start in IDLE: start dropped
        op    = 2'd1;
        rs    = 32'd9;
        rt    = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_dropped", 65'(busy), 65'(0));
        repeat (40) @(negedge clk);
        check("flush_start_hilo", {1'b0, hi, lo}, {33'b0, 32'd12});

        // Reset at cycle 20 of a DIVU
        start_op(2'd3, 32'd1000, 32'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midop_reset_flags", 65'({busy, done, dbz}), 65'(0));
        check("midop_reset_hilo", {1'b0, hi, lo}, 65'(0));
        check("midop_reset_state", 65'(dbg_state), 65'(0));
        exp_q.push_back({1'b0, 32'h0, 32'd4});
        start_op(2'd1, 32'd2, 32'd2);
        wait_done(1, cyc, bn);

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            r_op_v = 2'($urandom_range(0, 3));
            a_v    = $urandom;
            b_v    = $urandom;
            if (i % 2 == 1) b_v = b_v >> $urandom_range(16, 31);
            if (r_op_v[1] && b_v == 32'd0) b_v = 32'd1;
            exp_q.push_back(model(r_op_v, a_v, b_v));
            start_op(r_op_v, a_v, b_v);
            wait_done(1, cyc, bn);
            check("random_done_cycle", 65'(cyc), 65'(34));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 65'(exp_q.size()), 65'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
EX-stage iterative multiply/divide unit that consumes ID/EX pipeline-register outputs (operation, Rs/Rt operand data) and owns the architectural HI/LO registers. It accepts one operation at a time and holds `Busy__o` high while working, so hazard logic can stall the ID/EX register. It reports completion with a one-cycle `Done__o` pulse.

Parameters:
- `DATA_W`, default 32: operand width. HI and LO are each `DATA_W` bits.
- `CNT_W`, default 6: iteration counter width. Must satisfy 2^`CNT_W` > `DATA_W`.

Ports:
- `clock__i`, in, 1: clock. All state updates on its rising edge.
- `reset__i`, in, 1: synchronous, active-high reset.
- `Start__i`, in, 1: operation valid from ID/EX. Sampled only in `IDLE`.
- `Op__i`, in, 2: operation select. 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `RegRsData__i`, in, `DATA_W`: multiplicand or dividend.
- `RegRtData__i`, in, `DATA_W`: multiplier or divisor.
- `Flush__i`, in, 1: abort the in-flight operation.
- `Busy__o`, out, 1: unit occupied; used as a stall request.
- `Done__o`, out, 1: one-cycle pulse; HI/LO just updated (or div-by-zero reported).
- `DivByZero__o`, out, 1: one-cycle pulse coincident with `Done__o` for DIV/DIVU with Rt=0.
- `Hi__o`, out, `DATA_W`: HI register.
- `Lo__o`, out, `DATA_W`: LO register.

Behaviour:
- Reset: state=`IDLE`. `Busy__o`, `Done__o`, `DivByZero__o`, `Hi__o` and `Lo__o` all 0. Counter and datapath registers cleared.
- Priority at every edge: `reset__i` > `Flush__i` > normal operation.
- All outputs are registered.

State machine, states `IDLE`, `ITER`, `FIX`:
- `IDLE`: on `Start__i`=1 (edge E0), latch `Op__i`, the operand magnitudes and the result sign; clear the counter; go to `ITER`. `Busy__o`=1 from E0.
  - Special case: DIV/DIVU with Rt=0 goes to `FIX` instead; at E1 the unit pulses `Done__o` and `DivByZero__o` and leaves HI/LO unchanged.
- `ITER`: one radix-2 step per edge, `DATA_W` steps on E1..E32. The step at counter=`DATA_W`-1 moves to `FIX`.
  - Multiply step: shift-add on the 2·`DATA_W` accumulator.
  - Divide step: restoring shift-subtract, building the remainder and quotient.
- `FIX`: at E33 apply sign correction, write HI/LO, pulse `Done__o`=1, set `Busy__o`=0, return to `IDLE`.

Latency and throughput:
- 33 busy cycles; `Done__o` visible in the cycle after E33.
- A new `Start__i` is accepted in the `Done__o` cycle.
- `Start__i` while `Busy__o`=1 is ignored; no queuing.

Arithmetic rules:
- MULT/MULTU: {HI,LO} = 64-bit signed or unsigned product.
- DIV/DIVU: LO=quotient, HI=remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Signed operands are converted to magnitude using the unsigned 32-bit negate, so 0x80000000 maps to 0x80000000.
- 0x80000000 DIV 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.

Flush, reset and simultaneous events:
- `Flush__i` in `ITER`/`FIX`: go to `IDLE` next edge. HI/LO keep their old values, no `Done__o`, `Busy__o`=0.
- `Flush__i` together with `Start__i` in `IDLE`: the start is dropped.
- Reset mid-operation clears HI/LO to 0.

Decomposition:
- Shared package `muldiv_pkg` holds:
  - `muldiv_op_t` enum: `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - `muldiv_state_t` enum: `IDLE`, `ITER`, `FIX`.
  - `MULDIV_ITERS` constant.
- One natural sub-module, `muldiv_step`: combinational single-iteration datapath (shift-add or shift-subtract selected by op), instantiated once.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `Done__o` in cycle 34 after start; HI=0xFFFFFFFE, LO=0x00000001; `Busy__o` high for exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 7 / 0 after HI=0x11, LO=0x22 -> `Done__o` and `DivByZero__o` pulse at E1; HI=0x11, LO=0x22 unchanged.
- MULTU 3×4 started; extra `Start__i` held high at cycles 5–10 -> ignored, single `Done__o`, LO=12. Then restart with `Flush__i` at cycle 10 -> `Busy__o`=0 next cycle, no `Done__o`, LO stays 12.
- `reset__i` asserted at cycle 20 of a DIVU -> next cycle all outputs 0, state `IDLE`. A new MULTU 2×2 then completes with LO=4.
